// File: rtl/riscv_pkg.sv
// Shared types for the RV64I+Zba core: ALU opcodes, operand selects and
// the EX/MEM pipeline payload.
package riscv_pkg;

    localparam int XLEN  = 64;
    localparam int REG_W = 5;

    typedef enum logic [4:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_SLL,
        ALU_SLT,
        ALU_SLTU,
        ALU_XOR,
        ALU_SRL,
        ALU_SRA,
        ALU_OR,
        ALU_AND,
        ALU_ADDW,
        ALU_SUBW,
        ALU_SLLW,
        ALU_SRLW,
        ALU_SRAW,
        ALU_SH1ADD,
        ALU_SH2ADD,
        ALU_SH3ADD,
        ALU_ADD_UW,
        ALU_SH1ADD_UW,
        ALU_SH2ADD_UW,
        ALU_SH3ADD_UW,
        ALU_SLLI_UW,
        ALU_PASS_B
    } alu_op_t;

    localparam int ALU_OP_COUNT = 24;

    typedef enum logic [0:0] {
        SRC_A_RS1,
        SRC_A_PC
    } src_a_sel_t;

    typedef enum logic [1:0] {
        SRC_B_RS2,
        SRC_B_IMM,
        SRC_B_FOUR
    } src_b_sel_t;

    typedef struct packed {
        logic [XLEN-1:0]  result;
        logic [XLEN-1:0]  store_data;
        logic [REG_W-1:0] rd_addr;
        logic             reg_write;
        logic             mem_read;
        logic             mem_write;
    } ex_mem_t;

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

    function automatic logic [XLEN-1:0] zext32(input logic [31:0] v);
        return {32'd0, v};
    endfunction

endpackage

// File: rtl/alu.sv
// RV64I+Zba integer ALU, purely combinational. Word ops return results
// sign-extended to 64 bits.
module alu
    import riscv_pkg::*;
(
    input  alu_op_t         op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] result
);

    logic [5:0]      shamt;
    logic [4:0]      shamt_w;
    logic [31:0]     sum_w;
    logic [31:0]     diff_w;
    logic [31:0]     sll_w;
    logic [31:0]     srl_w;
    logic [31:0]     sra_w;
    logic [XLEN-1:0] a_uw;

    assign shamt   = b[5:0];
    assign shamt_w = b[4:0];
    assign sum_w   = a[31:0] + b[31:0];
    assign diff_w  = a[31:0] - b[31:0];
    assign sll_w   = a[31:0] << shamt_w;
    assign srl_w   = a[31:0] >> shamt_w;
    assign sra_w   = $signed(a[31:0]) >>> shamt_w;
    assign a_uw    = zext32(a[31:0]);

    always_comb begin
        // NOTE: default assigned first so every path drives result; no latch.
        result = '0;
        unique case (op)
            ALU_ADD:       result = a + b;
            ALU_SUB:       result = a - b;
            ALU_SLL:       result = a << shamt;
            ALU_SLT:       result = {63'd0, $signed(a) < $signed(b)};
            ALU_SLTU:      result = {63'd0, a < b};
            ALU_XOR:       result = a ^ b;
            ALU_SRL:       result = a >> shamt;
            ALU_SRA:       result = $signed(a) >>> shamt;
            ALU_OR:        result = a | b;
            ALU_AND:       result = a & b;
            ALU_ADDW:      result = sext32(sum_w);
            ALU_SUBW:      result = sext32(diff_w);
            ALU_SLLW:      result = sext32(sll_w);
            ALU_SRLW:      result = sext32(srl_w);
            ALU_SRAW:      result = sext32(sra_w);
            ALU_SH1ADD:    result = (a << 1) + b;
            ALU_SH2ADD:    result = (a << 2) + b;
            ALU_SH3ADD:    result = (a << 3) + b;
            ALU_ADD_UW:    result = a_uw + b;
            ALU_SH1ADD_UW: result = (a_uw << 1) + b;
            ALU_SH2ADD_UW: result = (a_uw << 2) + b;
            ALU_SH3ADD_UW: result = (a_uw << 3) + b;
            ALU_SLLI_UW:   result = a_uw << shamt;
            ALU_PASS_B:    result = b;
            default:       result = '0;
        endcase
    end

endmodule

// File: rtl/ex_fwd_unit.sv
// Per-source operand forwarding mux: EX/MEM beats MEM/WB beats the register
// file, and x0 always reads the register file value.
module ex_fwd_unit
    import riscv_pkg::*;
(
    input  logic [REG_W-1:0] rs_addr,
    input  logic [XLEN-1:0]  rf_data,
    input  logic             ex_valid,
    input  logic             ex_reg_write,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_rd_addr,
    input  logic [XLEN-1:0]  ex_result,
    input  logic             wb_reg_write,
    input  logic [REG_W-1:0] wb_rd_addr,
    input  logic [XLEN-1:0]  wb_data,
    output logic [XLEN-1:0]  fwd_data
);

    logic rs_nonzero;
    logic hit_ex;
    logic hit_wb;

    assign rs_nonzero = (rs_addr != '0);

    // A load in EX/MEM has no data yet; the hazard stall covers that case.
    assign hit_ex = rs_nonzero && ex_valid && ex_reg_write && !ex_mem_read
                    && (ex_rd_addr == rs_addr);
    assign hit_wb = rs_nonzero && wb_reg_write && (wb_rd_addr == rs_addr);

    always_comb begin
        fwd_data = rf_data;
        if (hit_ex) begin
            fwd_data = ex_result;
        end else if (hit_wb) begin
            fwd_data = wb_data;
        end
    end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, load-use stall, ALU and the EX/MEM
// pipeline register behind a valid/ready handshake.
module ex_stage
    import riscv_pkg::*;
(
    input  logic             clk,
    input  logic             rst,

    input  logic             id_valid_i,
    output logic             id_ready_o,
    input  logic [XLEN-1:0]  id_pc_i,
    input  logic [XLEN-1:0]  id_rs1_data_i,
    input  logic [XLEN-1:0]  id_rs2_data_i,
    input  logic [XLEN-1:0]  id_imm_i,
    input  logic [REG_W-1:0] id_rs1_addr_i,
    input  logic [REG_W-1:0] id_rs2_addr_i,
    input  logic [REG_W-1:0] id_rd_addr_i,
    input  alu_op_t          id_alu_op_i,
    input  src_a_sel_t       id_src_a_sel_i,
    input  src_b_sel_t       id_src_b_sel_i,
    input  logic             id_reg_write_i,
    input  logic             id_mem_read_i,
    input  logic             id_mem_write_i,

    input  logic             flush_i,
    input  logic             mem_ready_i,

    input  logic             wb_reg_write_i,
    input  logic [REG_W-1:0] wb_rd_addr_i,
    input  logic [XLEN-1:0]  wb_data_i,

    output logic             ex_valid_o,
    output logic [XLEN-1:0]  ex_result_o,
    output logic [XLEN-1:0]  ex_store_data_o,
    output logic [REG_W-1:0] ex_rd_addr_o,
    output logic             ex_reg_write_o,
    output logic             ex_mem_read_o,
    output logic             ex_mem_write_o
);

    logic            ex_valid_q;
    ex_mem_t         ex_mem_q;
    ex_mem_t         ex_mem_d;

    logic [XLEN-1:0] rs1_fwd;
    logic [XLEN-1:0] rs2_fwd;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic [XLEN-1:0] alu_result;

    logic            rs1_used;
    logic            rs2_used;
    logic            load_in_ex;
    logic            hazard;
    logic            slot_free;
    logic            accept;

    ex_fwd_unit u_fwd_rs1 (
        .rs_addr      (id_rs1_addr_i),
        .rf_data      (id_rs1_data_i),
        .ex_valid     (ex_valid_q),
        .ex_reg_write (ex_mem_q.reg_write),
        .ex_mem_read  (ex_mem_q.mem_read),
        .ex_rd_addr   (ex_mem_q.rd_addr),
        .ex_result    (ex_mem_q.result),
        .wb_reg_write (wb_reg_write_i),
        .wb_rd_addr   (wb_rd_addr_i),
        .wb_data      (wb_data_i),
        .fwd_data     (rs1_fwd)
    );

    ex_fwd_unit u_fwd_rs2 (
        .rs_addr      (id_rs2_addr_i),
        .rf_data      (id_rs2_data_i),
        .ex_valid     (ex_valid_q),
        .ex_reg_write (ex_mem_q.reg_write),
        .ex_mem_read  (ex_mem_q.mem_read),
        .ex_rd_addr   (ex_mem_q.rd_addr),
        .ex_result    (ex_mem_q.result),
        .wb_reg_write (wb_reg_write_i),
        .wb_rd_addr   (wb_rd_addr_i),
        .wb_data      (wb_data_i),
        .fwd_data     (rs2_fwd)
    );

    always_comb begin
        op_a = rs1_fwd;
        unique case (id_src_a_sel_i)
            SRC_A_RS1: op_a = rs1_fwd;
            SRC_A_PC:  op_a = id_pc_i;
            default:   op_a = rs1_fwd;
        endcase
    end

    always_comb begin
        op_b = rs2_fwd;
        unique case (id_src_b_sel_i)
            SRC_B_RS2:  op_b = rs2_fwd;
            SRC_B_IMM:  op_b = id_imm_i;
            SRC_B_FOUR: op_b = 64'd4;
            default:    op_b = rs2_fwd;
        endcase
    end

    alu u_alu (
        .op     (id_alu_op_i),
        .a      (op_a),
        .b      (op_b),
        .result (alu_result)
    );

    // Stores consume rs2 as data even when operand B is the immediate.
    assign rs1_used   = (id_src_a_sel_i == SRC_A_RS1);
    assign rs2_used   = (id_src_b_sel_i == SRC_B_RS2) || id_mem_write_i;
    assign load_in_ex = ex_valid_q && ex_mem_q.mem_read && (ex_mem_q.rd_addr != '0);
    assign hazard     = load_in_ex
                        && ((rs1_used && (ex_mem_q.rd_addr == id_rs1_addr_i))
                         || (rs2_used && (ex_mem_q.rd_addr == id_rs2_addr_i)));

    assign slot_free  = !ex_valid_q || mem_ready_i;
    assign id_ready_o = slot_free && !hazard;
    assign accept     = id_valid_i && id_ready_o && !flush_i;

    always_comb begin
        ex_mem_d.result     = alu_result;
        ex_mem_d.store_data = rs2_fwd;
        ex_mem_d.rd_addr    = id_rd_addr_i;
        ex_mem_d.reg_write  = id_reg_write_i;
        ex_mem_d.mem_read   = id_mem_read_i;
        ex_mem_d.mem_write  = id_mem_write_i;
    end

    // NOTE: clocked state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid_q <= 1'b0;
            ex_mem_q   <= '0;
        end else if (slot_free) begin
            if (accept) begin
                ex_valid_q <= 1'b1;
                ex_mem_q   <= ex_mem_d;
            end else begin
                // NOTE: a bubble clears only the control bits; data fields
                // keep stale values because nothing reads them while invalid.
                ex_valid_q         <= 1'b0;
                ex_mem_q.reg_write <= 1'b0;
                ex_mem_q.mem_read  <= 1'b0;
                ex_mem_q.mem_write <= 1'b0;
            end
        end
    end

    assign ex_valid_o      = ex_valid_q;
    assign ex_result_o     = ex_mem_q.result;
    assign ex_store_data_o = ex_mem_q.store_data;
    assign ex_rd_addr_o    = ex_mem_q.rd_addr;
    assign ex_reg_write_o  = ex_mem_q.reg_write;
    assign ex_mem_read_o   = ex_mem_q.mem_read;
    assign ex_mem_write_o  = ex_mem_q.mem_write;

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed scenarios followed by random
// traffic, both compared against a cycle-level architectural model.
module tb_ex_stage;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid_i;
    logic        id_ready_o;
    logic [63:0] id_pc_i;
    logic [63:0] id_rs1_data_i;
    logic [63:0] id_rs2_data_i;
    logic [63:0] id_imm_i;
    logic [4:0]  id_rs1_addr_i;
    logic [4:0]  id_rs2_addr_i;
    logic [4:0]  id_rd_addr_i;
    alu_op_t     id_alu_op_i;
    src_a_sel_t  id_src_a_sel_i;
    src_b_sel_t  id_src_b_sel_i;
    logic        id_reg_write_i;
    logic        id_mem_read_i;
    logic        id_mem_write_i;
    logic        flush_i;
    logic        mem_ready_i;
    logic        wb_reg_write_i;
    logic [4:0]  wb_rd_addr_i;
    logic [63:0] wb_data_i;
    logic        ex_valid_o;
    logic [63:0] ex_result_o;
    logic [63:0] ex_store_data_o;
    logic [4:0]  ex_rd_addr_o;
    logic        ex_reg_write_o;
    logic        ex_mem_read_o;
    logic        ex_mem_write_o;

    int total = 0;
    int bad   = 0;

    // Architectural model of the EX/MEM register contents.
    logic        m_valid;
    logic        m_known;
    logic [63:0] m_result;
    logic [63:0] m_store;
    logic [4:0]  m_rd;
    logic        m_rw;
    logic        m_mr;
    logic        m_mw;

    logic [63:0] held_result;

    always #5 clk = ~clk;

    ex_stage dut (
        .clk             (clk),
        .rst             (rst),
        .id_valid_i      (id_valid_i),
        .id_ready_o      (id_ready_o),
        .id_pc_i         (id_pc_i),
        .id_rs1_data_i   (id_rs1_data_i),
        .id_rs2_data_i   (id_rs2_data_i),
        .id_imm_i        (id_imm_i),
        .id_rs1_addr_i   (id_rs1_addr_i),
        .id_rs2_addr_i   (id_rs2_addr_i),
        .id_rd_addr_i    (id_rd_addr_i),
        .id_alu_op_i     (id_alu_op_i),
        .id_src_a_sel_i  (id_src_a_sel_i),
        .id_src_b_sel_i  (id_src_b_sel_i),
        .id_reg_write_i  (id_reg_write_i),
        .id_mem_read_i   (id_mem_read_i),
        .id_mem_write_i  (id_mem_write_i),
        .flush_i         (flush_i),
        .mem_ready_i     (mem_ready_i),
        .wb_reg_write_i  (wb_reg_write_i),
        .wb_rd_addr_i    (wb_rd_addr_i),
        .wb_data_i       (wb_data_i),
        .ex_valid_o      (ex_valid_o),
        .ex_result_o     (ex_result_o),
        .ex_store_data_o (ex_store_data_o),
        .ex_rd_addr_o    (ex_rd_addr_o),
        .ex_reg_write_o  (ex_reg_write_o),
        .ex_mem_read_o   (ex_mem_read_o),
        .ex_mem_write_o  (ex_mem_write_o)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] sx(input logic [63:0] v);
        return {{32{v[31]}}, v[31:0]};
    endfunction

    // Instruction semantics written from the ISA definitions.
    function automatic logic [63:0] ref_alu(input alu_op_t op, input logic [63:0] a, input logic [63:0] b);
        logic [63:0] lo;
        logic [63:0] t;
        lo = a & 64'h0000_0000_FFFF_FFFF;
        case (op)
            ALU_ADD:       return a + b;
            ALU_SUB:       return a - b;
            ALU_SLL:       return a << b[5:0];
            ALU_SLT:       return ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
            ALU_SLTU:      return (a < b) ? 64'd1 : 64'd0;
            ALU_XOR:       return a ^ b;
            ALU_SRL:       return a >> b[5:0];
            ALU_SRA:       begin t = $signed(a) >>> b[5:0]; return t; end
            ALU_OR:        return a | b;
            ALU_AND:       return a & b;
            ALU_ADDW:      return sx(a + b);
            ALU_SUBW:      return sx(a - b);
            ALU_SLLW:      return sx(a << b[4:0]);
            ALU_SRLW:      return sx(lo >> b[4:0]);
            ALU_SRAW:      begin t = $signed(sx(a)) >>> b[4:0]; return sx(t); end
            ALU_SH1ADD:    return a * 64'd2 + b;
            ALU_SH2ADD:    return a * 64'd4 + b;
            ALU_SH3ADD:    return a * 64'd8 + b;
            ALU_ADD_UW:    return lo + b;
            ALU_SH1ADD_UW: return lo * 64'd2 + b;
            ALU_SH2ADD_UW: return lo * 64'd4 + b;
            ALU_SH3ADD_UW: return lo * 64'd8 + b;
            ALU_SLLI_UW:   return lo << b[5:0];
            ALU_PASS_B:    return b;
            default:       return 64'd0;
        endcase
    endfunction

    function automatic logic [63:0] ref_operand(input logic [4:0] rs, input logic [63:0] rf);
        if (rs == 5'd0) return rf;
        if (m_valid && m_rw && !m_mr && m_rd == rs) return m_result;
        if (wb_reg_write_i && wb_rd_addr_i == rs) return wb_data_i;
        return rf;
    endfunction

    function automatic logic ref_ready();
        logic use1;
        logic use2;
        logic hz;
        use1 = (id_src_a_sel_i == SRC_A_RS1) && (m_rd == id_rs1_addr_i);
        use2 = ((id_src_b_sel_i == SRC_B_RS2) || id_mem_write_i) && (m_rd == id_rs2_addr_i);
        hz   = m_valid && m_mr && (m_rd != 5'd0) && (use1 || use2);
        return (!m_valid || mem_ready_i) && !hz;
    endfunction

    // One clock: check the combinational ready, advance the model, check outputs.
    task automatic cycle();
        logic        rdy;
        logic        acc;
        logic [63:0] r1;
        logic [63:0] r2;
        logic [63:0] a;
        logic [63:0] b;
        #1;
        rdy = ref_ready();
        check("id_ready_o", 64'(id_ready_o), 64'(rdy));
        r1 = ref_operand(id_rs1_addr_i, id_rs1_data_i);
        r2 = ref_operand(id_rs2_addr_i, id_rs2_data_i);
        a  = (id_src_a_sel_i == SRC_A_PC) ? id_pc_i : r1;
        b  = (id_src_b_sel_i == SRC_B_IMM)  ? id_imm_i :
             (id_src_b_sel_i == SRC_B_FOUR) ? 64'd4 : r2;
        acc = id_valid_i && rdy && !flush_i;
        @(posedge clk);
        if (rst) begin
            m_valid = 1'b0; m_known = 1'b1; m_result = '0; m_store = '0;
            m_rd = '0; m_rw = 1'b0; m_mr = 1'b0; m_mw = 1'b0;
        end else if (m_valid && !mem_ready_i) begin
            m_valid = m_valid;
        end else if (acc) begin
            m_valid = 1'b1; m_known = 1'b1;
            m_result = ref_alu(id_alu_op_i, a, b); m_store = r2;
            m_rd = id_rd_addr_i; m_rw = id_reg_write_i;
            m_mr = id_mem_read_i; m_mw = id_mem_write_i;
        end else begin
            m_valid = 1'b0; m_known = 1'b0;
            m_rw = 1'b0; m_mr = 1'b0; m_mw = 1'b0;
        end
        #1;
        check("ex_valid_o",     64'(ex_valid_o),     64'(m_valid));
        check("ex_reg_write_o", 64'(ex_reg_write_o), 64'(m_rw));
        check("ex_mem_read_o",  64'(ex_mem_read_o),  64'(m_mr));
        check("ex_mem_write_o", 64'(ex_mem_write_o), 64'(m_mw));
        if (m_known) begin
            check("ex_result_o",     ex_result_o,        m_result);
            check("ex_store_data_o", ex_store_data_o,    m_store);
            check("ex_rd_addr_o",    64'(ex_rd_addr_o),  64'(m_rd));
        end
    endtask

    task automatic idle();
        id_valid_i = 1'b0; id_pc_i = 64'h1000; id_rs1_data_i = '0; id_rs2_data_i = '0;
        id_imm_i = '0; id_rs1_addr_i = '0; id_rs2_addr_i = '0; id_rd_addr_i = '0;
        id_alu_op_i = ALU_ADD; id_src_a_sel_i = SRC_A_RS1; id_src_b_sel_i = SRC_B_RS2;
        id_reg_write_i = 1'b0; id_mem_read_i = 1'b0; id_mem_write_i = 1'b0;
        flush_i = 1'b0;
    endtask

    task automatic issue(input alu_op_t op, input src_a_sel_t sa, input src_b_sel_t sb,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic [63:0] d1, input logic [63:0] d2, input logic [63:0] imm,
                         input logic rw, input logic mr, input logic mw);
        id_valid_i = 1'b1; id_alu_op_i = op; id_src_a_sel_i = sa; id_src_b_sel_i = sb;
        id_rs1_addr_i = rs1; id_rs2_addr_i = rs2; id_rd_addr_i = rd;
        id_rs1_data_i = d1; id_rs2_data_i = d2; id_imm_i = imm;
        id_reg_write_i = rw; id_mem_read_i = mr; id_mem_write_i = mw;
    endtask

    task automatic wb_set(input logic we, input logic [4:0] rd, input logic [63:0] d);
        wb_reg_write_i = we; wb_rd_addr_i = rd; wb_data_i = d;
    endtask

    initial begin
        m_valid = 1'b0; m_known = 1'b0; m_result = '0; m_store = '0;
        m_rd = '0; m_rw = 1'b0; m_mr = 1'b0; m_mw = 1'b0;
        rst = 1'b1; mem_ready_i = 1'b1;
        idle();
        wb_set(1'b0, 5'd0, 64'd0);

        // Reset, then the first cycle must be ready with all outputs cleared.
        cycle();
        rst = 1'b0;
        check("rst_valid",  64'(ex_valid_o), 64'd0);
        check("rst_result", ex_result_o, 64'd0);
        check("rst_ready",  64'(id_ready_o), 64'd1);

        // ADD x3,x1,x2 without forwarding.
        issue(ALU_ADD, SRC_A_RS1, SRC_B_RS2, 5'd1, 5'd2, 5'd3, 64'd5, 64'd7, 64'd0, 1'b1, 1'b0, 1'b0);
        cycle();
        check("add_result", ex_result_o, 64'd12);
        check("add_rd",     64'(ex_rd_addr_o), 64'd3);
        check("add_valid",  64'(ex_valid_o), 64'd1);
        idle(); cycle();

        // ADDI x1,x0,10 then SH2ADD x2,x1,x1 with stale RF: EX/MEM path, then EX/MEM over WB.
        for (int pass = 0; pass < 2; pass++) begin
            issue(ALU_ADD, SRC_A_RS1, SRC_B_IMM, 5'd0, 5'd0, 5'd1, 64'd0, 64'd0, 64'd10, 1'b1, 1'b0, 1'b0);
            cycle();
            issue(ALU_SH2ADD, SRC_A_RS1, SRC_B_RS2, 5'd1, 5'd1, 5'd2, 64'd0, 64'd0, 64'd0, 1'b1, 1'b0, 1'b0);
            if (pass == 1) wb_set(1'b1, 5'd1, 64'd99);
            cycle();
            check("sh2add_fwd", ex_result_o, 64'd50);
            wb_set(1'b0, 5'd0, 64'd0);
            idle(); cycle();
        end

        // LD x5 then ADD x6,x5,x5: one bubble, then forward from WB.
        issue(ALU_ADD, SRC_A_RS1, SRC_B_IMM, 5'd10, 5'd0, 5'd5, 64'h1000, 64'd0, 64'd8, 1'b1, 1'b1, 1'b0);
        cycle();
        issue(ALU_ADD, SRC_A_RS1, SRC_B_RS2, 5'd5, 5'd5, 5'd6, 64'd0, 64'd0, 64'd0, 1'b1, 1'b0, 1'b0);
        #1;
        check("loaduse_ready", 64'(id_ready_o), 64'd0);
        cycle();
        check("loaduse_bubble", 64'(ex_valid_o), 64'd0);
        wb_set(1'b1, 5'd5, 64'h21);
        cycle();
        check("loaduse_result", ex_result_o, 64'h42);
        check("loaduse_valid",  64'(ex_valid_o), 64'd1);
        wb_set(1'b0, 5'd0, 64'd0);
        idle(); cycle();

        // SUB giving all ones, then 3 cycles of backpressure and release.
        issue(ALU_SUB, SRC_A_RS1, SRC_B_RS2, 5'd8, 5'd9, 5'd7, 64'd0, 64'd1, 64'd0, 1'b1, 1'b0, 1'b0);
        cycle();
        check("sub_result", ex_result_o, 64'hFFFF_FFFF_FFFF_FFFF);
        held_result = ex_result_o;
        issue(ALU_ADD, SRC_A_RS1, SRC_B_RS2, 5'd12, 5'd13, 5'd14, 64'd3, 64'd4, 64'd0, 1'b1, 1'b0, 1'b0);
        mem_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_ready", 64'(id_ready_o), 64'd0);
            cycle();
            check("bp_hold_result", ex_result_o, held_result);
            check("bp_hold_rd",     64'(ex_rd_addr_o), 64'd7);
        end
        mem_ready_i = 1'b1;
        #1;
        check("bp_release_ready", 64'(id_ready_o), 64'd1);
        cycle();
        check("bp_release_result", ex_result_o, 64'd7);

        // Flush kills the presented instruction.
        issue(ALU_ADD, SRC_A_RS1, SRC_B_RS2, 5'd1, 5'd2, 5'd3, 64'd1, 64'd1, 64'd0, 1'b1, 1'b0, 1'b0);
        flush_i = 1'b1;
        cycle();
        check("flush_valid", 64'(ex_valid_o), 64'd0);
        flush_i = 1'b0;

        // Write to x0 then use x0: never forwarded from either stage.
        issue(ALU_ADD, SRC_A_RS1, SRC_B_IMM, 5'd0, 5'd0, 5'd0, 64'd0, 64'd0, 64'd77, 1'b1, 1'b0, 1'b0);
        cycle();
        issue(ALU_ADD, SRC_A_RS1, SRC_B_RS2, 5'd0, 5'd0, 5'd11, 64'd0, 64'd0, 64'd0, 1'b1, 1'b0, 1'b0);
        wb_set(1'b1, 5'd0, 64'd55);
        cycle();
        check("x0_result", ex_result_o, 64'd0);
        wb_set(1'b0, 5'd0, 64'd0);

        // Reset during backpressure.
        issue(ALU_SUB, SRC_A_RS1, SRC_B_RS2, 5'd8, 5'd9, 5'd7, 64'd0, 64'd1, 64'd0, 1'b1, 1'b1, 1'b1);
        cycle();
        mem_ready_i = 1'b0;
        cycle();
        rst = 1'b1;
        cycle();
        check("rst_bp_valid", 64'(ex_valid_o), 64'd0);
        check("rst_bp_result", ex_result_o, 64'd0);
        check("rst_bp_store", ex_store_data_o, 64'd0);
        check("rst_bp_ctrl", {61'd0, ex_reg_write_o, ex_mem_read_o, ex_mem_write_o}, 64'd0);
        check("rst_bp_ready", 64'(id_ready_o), 64'd1);
        rst = 1'b0;
        mem_ready_i = 1'b1;
        idle();

        // Random traffic over a small register window to provoke hazards.
        for (int n = 0; n < 600; n++) begin
            id_valid_i     = ($urandom % 4) != 0;
            id_alu_op_i    = alu_op_t'($urandom_range(0, ALU_OP_COUNT - 1));
            id_src_a_sel_i = src_a_sel_t'($urandom_range(0, 1));
            id_src_b_sel_i = src_b_sel_t'($urandom_range(0, 2));
            id_rs1_addr_i  = 5'($urandom_range(0, 3));
            id_rs2_addr_i  = 5'($urandom_range(0, 3));
            id_rd_addr_i   = 5'($urandom_range(0, 3));
            id_rs1_data_i  = {$urandom, $urandom};
            id_rs2_data_i  = {$urandom, $urandom};
            id_imm_i       = {$urandom, $urandom};
            id_pc_i        = {32'd0, $urandom};
            id_reg_write_i = 1'($urandom_range(0, 1));
            id_mem_read_i  = 1'($urandom_range(0, 1));
            id_mem_write_i = 1'($urandom_range(0, 1));
            flush_i        = ($urandom % 8) == 0;
            mem_ready_i    = ($urandom % 4) != 0;
            wb_set(1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), {$urandom, $urandom});
            rst            = ($urandom % 64) == 0;
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
